// File: rtl/result_writeback.sv
// result_writeback
// Collects filter results into a small FIFO and writes them to memory in raster
// order over a request/acknowledge handshake. One output frame of
// IMAGE_WIDTH x IMAGE_HEIGHT pixels is written per start pulse. The done flag is
// raised after the last pixel is acknowledged and held until the next start.
module result_writeback #(
  parameter int unsigned IMAGE_WIDTH  = 512,
  parameter int unsigned IMAGE_HEIGHT = 288,
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned BUS_WIDTH    = 32,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  WB_CLK,
  input  logic                  WB_RST,
  input  logic                  WB_STRT,
  input  logic                  WB_FDNE,
  input  logic [DATA_WIDTH-1:0] WB_FRES,
  input  logic                  WB_MEMRDY,
  output logic [1:0]            WB_MEMRW,
  output logic [BUS_WIDTH-1:0]  WB_MEMADDR,
  output logic [DATA_WIDTH-1:0] WB_MEMDATA,
  output logic                  WB_FULL,
  output logic                  WB_OVF,
  output logic                  WB_DNE
);

  // Pointer width relies on FIFO_DEPTH being a power of two so pointers wrap
  // naturally; the occupancy counter needs one extra bit to represent "full".
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  localparam logic [OCC_W-1:0]     OCC_FULL   = OCC_W'(FIFO_DEPTH);
  localparam logic [BUS_WIDTH-1:0] BASE       = BUS_WIDTH'(BASE_ADDR);
  localparam logic [BUS_WIDTH-1:0] LAST_COUNT = BUS_WIDTH'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

  // Memory command encodings. The read encoding (2'b01) is never issued here.
  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_WRITE,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic                  r_full;
  logic                  r_ovf;
  logic                  r_dne;
  logic [BUS_WIDTH-1:0]  r_count;
  logic [1:0]            r_memrw;
  logic [BUS_WIDTH-1:0]  r_memaddr;
  logic [DATA_WIDTH-1:0] r_memdata;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic             w_accept;
  logic             w_pop;
  logic             w_fifo_full;
  logic             w_push;
  logic             w_drop;
  logic             w_last;
  logic             w_flush;
  logic [OCC_W-1:0] w_occ_next;

  // Results are only taken while a frame is in progress.
  assign w_accept    = WB_FDNE && ((r_state == S_ARMED) || (r_state == S_WRITE));
  // The acknowledge only means something while a write is on the bus.
  assign w_pop       = (r_state == S_WRITE) && WB_MEMRDY;
  assign w_fifo_full = (r_occ == OCC_FULL);
  // A full FIFO still takes a result if its head leaves on the same edge.
  assign w_push      = w_accept && (!w_fifo_full || w_pop);
  assign w_drop      = w_accept && w_fifo_full && !w_pop;
  assign w_last      = (r_count == LAST_COUNT);
  // Once the frame is complete any buffered surplus is discarded.
  assign w_flush     = (r_state == S_DONE) || (w_pop && w_last);

  // Next FIFO occupancy, shared by the counter and the registered full flag.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal
    // unassigned; an unassigned path in always_comb infers a latch.
    w_occ_next = r_occ;
    if (w_flush) begin
      w_occ_next = '0;
    end else begin
      w_occ_next = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end

  // FIFO storage: write the incoming result at the tail.
  // NOTE: the data array is deliberately not reset; pointers and occupancy
  // define which entries are valid, and leaving the array reset-free lets it
  // map to plain storage without a reset network.
  always_ff @(posedge WB_CLK) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= WB_FRES;
    end
  end

  // FIFO bookkeeping: pointers, occupancy and the registered full flag.
  always_ff @(posedge WB_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (WB_RST) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
      end
      r_occ  <= w_occ_next;
      r_full <= (w_occ_next == OCC_FULL);
    end
  end

  // Frame sequencer with registered memory command, address, data and flags.
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_dne     <= 1'b0;
      r_memrw   <= CMD_IDLE;
      r_memaddr <= '0;
      r_memdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (WB_STRT) begin
            r_state <= S_ARMED;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_dne   <= 1'b0;
          end
        end

        S_ARMED: begin
          // Launch a write as soon as a result is buffered; the command,
          // address and data are registered together and then held.
          if (r_occ != '0) begin
            r_state   <= S_WRITE;
            r_memrw   <= CMD_WRITE;
            r_memaddr <= BASE + r_count;
            r_memdata <= r_fifo[r_rd_ptr];
          end
        end

        S_WRITE: begin
          // Hold the bus until memory acknowledges, then return to idle for
          // at least one cycle before the next write.
          if (WB_MEMRDY) begin
            r_memrw <= CMD_IDLE;
            r_count <= r_count + BUS_WIDTH'(1);
            if (w_last) begin
              r_state <= S_DONE;
              r_dne   <= 1'b1;
            end else begin
              r_state <= S_ARMED;
            end
          end
        end

        S_DONE: begin
          if (WB_STRT) begin
            r_state <= S_ARMED;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_dne   <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_memrw <= CMD_IDLE;
        end
      endcase

      // Overflow is sticky for the frame; drops only happen in ARMED/WRITE,
      // where no start can clear it on the same edge.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign WB_MEMRW   = r_memrw;
  assign WB_MEMADDR = r_memaddr;
  assign WB_MEMDATA = r_memdata;
  assign WB_FULL    = r_full;
  assign WB_OVF     = r_ovf;
  assign WB_DNE     = r_dne;

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback with a 4x2 frame at base 0x100 and a
// four-entry FIFO. Inputs are driven and outputs sampled 1 ns after each
// rising edge; every expected value is written out by hand.
module tb_result_writeback;

  localparam int unsigned DW = 24;
  localparam int unsigned BW = 32;

  logic          clk;
  logic          rst;
  logic          strt;
  logic          fdne;
  logic [DW-1:0] fres;
  logic          memrdy;
  logic [1:0]    memrw;
  logic [BW-1:0] memaddr;
  logic [DW-1:0] memdata;
  logic          full;
  logic          ovf;
  logic          dne;

  int n_cmp  = 0;
  int n_fail = 0;

  result_writeback #(
    .IMAGE_WIDTH (4),
    .IMAGE_HEIGHT(2),
    .DATA_WIDTH  (DW),
    .BUS_WIDTH   (BW),
    .BASE_ADDR   (32'h100),
    .FIFO_DEPTH  (4)
  ) dut (
    .WB_CLK    (clk),
    .WB_RST    (rst),
    .WB_STRT   (strt),
    .WB_FDNE   (fdne),
    .WB_FRES   (fres),
    .WB_MEMRDY (memrdy),
    .WB_MEMRW  (memrw),
    .WB_MEMADDR(memaddr),
    .WB_MEMDATA(memdata),
    .WB_FULL   (full),
    .WB_OVF    (ovf),
    .WB_DNE    (dne)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " memrw"},   64'(memrw),   64'h0);
    check({tag, " memaddr"}, 64'(memaddr), 64'h0);
    check({tag, " memdata"}, 64'(memdata), 64'h0);
    check({tag, " full"},    64'(full),    64'h0);
    check({tag, " ovf"},     64'(ovf),     64'h0);
    check({tag, " dne"},     64'(dne),     64'h0);
  endtask

  // One strobe followed by one idle cycle; with MEMRDY high this keeps the
  // FIFO at one entry and the new result appears on the bus one edge later.
  task automatic strobe_write(input logic [DW-1:0] val, input logic [BW-1:0] addr);
    fdne = 1'b1;
    fres = val;
    tick();
    fdne = 1'b0;
    tick();
    check("wr memrw", 64'(memrw),   64'h2);
    check("wr addr",  64'(memaddr), 64'(addr));
    check("wr data",  64'(memdata), 64'(val));
  endtask

  task automatic pulse_start();
    strt = 1'b1;
    tick();
    strt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    strt   = 1'b0;
    fdne   = 1'b0;
    fres   = '0;
    memrdy = 1'b0;

    // Reset held for two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      strt   = 1'($urandom);
      fdne   = 1'($urandom);
      fres   = DW'($urandom);
      memrdy = 1'($urandom);
      tick();
    end
    check_idle_outputs("reset");
    rst    = 1'b0;
    strt   = 1'b0;
    fdne   = 1'b0;
    memrdy = 1'b0;
    tick();

    // Strobes in IDLE are ignored: no push, no overflow, no write.
    memrdy = 1'b1;
    fdne   = 1'b1;
    fres   = 24'h000077;
    for (int i = 0; i < 5; i++) tick();
    fdne = 1'b0;
    tick();
    check_idle_outputs("idle strobes");

    // Full frame with MEMRDY tied high: 0x000001..0x000008 to 0x100..0x107.
    pulse_start();
    check("armed memrw", 64'(memrw), 64'h0);
    for (int i = 1; i <= 8; i++) begin
      strobe_write(DW'(i), BW'(32'h100 + i - 1));
      if (i < 8) check("dne early", 64'(dne), 64'h0);
    end
    check("last dne pre-ack", 64'(dne), 64'h0);
    tick();
    check("frame dne", 64'(dne), 64'h1);
    check("frame done memrw", 64'(memrw), 64'h0);
    check("frame done ovf", 64'(ovf), 64'h0);

    // Strobes in DONE are ignored; DNE holds.
    fdne = 1'b1;
    fres = 24'h0000AA;
    for (int i = 0; i < 6; i++) tick();
    fdne = 1'b0;
    tick();
    check("done dne held", 64'(dne), 64'h1);
    check("done full", 64'(full), 64'h0);
    check("done ovf", 64'(ovf), 64'h0);
    check("done memrw", 64'(memrw), 64'h0);

    // STRT in DONE clears DNE and re-arms at the base address.
    memrdy = 1'b0;
    pulse_start();
    check("restart dne", 64'(dne), 64'h0);

    // MEMRDY low: write held stable with no pop.
    fdne = 1'b1;
    fres = 24'h000011;
    tick();
    fdne = 1'b0;
    tick();
    check("stall memrw", 64'(memrw),   64'h2);
    check("stall addr",  64'(memaddr), 64'h100);
    check("stall data",  64'(memdata), 64'h11);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold memrw", 64'(memrw),   64'h2);
      check("hold addr",  64'(memaddr), 64'h100);
      check("hold data",  64'(memdata), 64'h11);
    end

    // Fill the FIFO: 0x11 already inside, then 0x12..0x15 back to back.
    fdne = 1'b1;
    fres = 24'h000012;
    tick();
    check("fill2 full", 64'(full), 64'h0);
    fres = 24'h000013;
    tick();
    check("fill3 full", 64'(full), 64'h0);
    fres = 24'h000014;
    tick();
    check("fill4 full", 64'(full), 64'h1);
    check("fill4 ovf",  64'(ovf),  64'h0);
    fres = 24'h000015;
    tick();
    check("fill5 full", 64'(full), 64'h1);
    check("fill5 ovf",  64'(ovf),  64'h1);
    fdne = 1'b0;

    // Release MEMRDY: exactly the first four results are written.
    memrdy = 1'b1;
    check("drain0 addr", 64'(memaddr), 64'h100);
    check("drain0 data", 64'(memdata), 64'h11);
    tick();
    check("drain0 memrw idle", 64'(memrw), 64'h0);
    check("drain0 full", 64'(full), 64'h0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("drain memrw", 64'(memrw),   64'h2);
      check("drain addr",  64'(memaddr), 64'(32'h100 + i));
      check("drain data",  64'(memdata), 64'(32'h11 + i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dropped never written", 64'(memrw), 64'h0);
    end
    check("ovf sticky", 64'(ovf), 64'h1);
    check("partial dne", 64'(dne), 64'h0);

    // Reset mid-frame abandons everything, including the sticky overflow.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("midframe reset");
    tick();

    // Three writes of a new frame, then reset after the third is acknowledged.
    pulse_start();
    strobe_write(24'h000021, 32'h100);
    strobe_write(24'h000022, 32'h101);
    strobe_write(24'h000023, 32'h102);
    tick();
    check("third acked memrw", 64'(memrw), 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("reset after 3");
    tick();

    // Fresh frame restarts at the base address and completes.
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      strobe_write(DW'(32'h31 + i), BW'(32'h100 + i));
    end
    tick();
    check("refrm dne", 64'(dne), 64'h1);
    check("refrm memrw", 64'(memrw), 64'h0);
    tick();
    tick();
    check("refrm dne held", 64'(dne), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
